mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port instruction/data memory between the IF stage (fetch, read-only)
//  and the MEM stage (load/store) of the 5-stage pipeline.
//  Serializes accesses with a registered FSM and drives the pipeline freeze (IF) and mem_stall (MEM) signals.
//  MEM has priority over IF. A starvation counter forces an IF grant after STARVE_LIMIT consecutive MEM wins.
// PARAMETERS
//  ADDRESS_LEN   32  address width, all ports
//  DATA_LEN      32  data/instruction width
//  STARVE_LIMIT  3   MEM-over-IF wins before IF is forced (>=1)
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            synchronous, active-low reset (rst==0 resets on clk edge)
//  if_req     in   1            fetch request, held until if_done
//  if_addr    in   ADDRESS_LEN  fetch address, stable while if_req
//  if_rdata   out  DATA_LEN     fetched instruction, valid when if_done
//  if_done    out  1            1-cycle completion pulse, IF
//  mem_req    in   1            data request, held until mem_done
//  mem_wr     in   1            1=store, 0=load
//  mem_addr   in   ADDRESS_LEN  data address
//  mem_wdata  in   DATA_LEN     store data
//  mem_rdata  out  DATA_LEN     load data, valid when mem_done
//  mem_done   out  1            1-cycle completion pulse, MEM
//  ram_en     out  1            memory access active
//  ram_we     out  1            memory write enable
//  ram_addr   out  ADDRESS_LEN  memory address
//  ram_wdata  out  DATA_LEN     memory write data
//  ram_rdata  in   DATA_LEN     memory read data, valid with ram_ready
//  ram_ready  in   1            access complete this cycle (may be 1 in first cycle)
//  freeze     out  1            = if_req & ~if_done, to IF stage and IF stage reg
//  mem_stall  out  1            = mem_req & ~mem_done, holds EX/MEM/WB regs
// BEHAVIOUR
//  States: IDLE, SERVE_IF, SERVE_MEM, RESP. All state, ram_*, *_rdata and *_done are registered.
//  Reset (rst==0 at edge): state=IDLE; ram_en/ram_we=0; ram_addr/ram_wdata/if_rdata/mem_rdata=0;
//   if_done/mem_done=0; starve_cnt=0.
//  freeze and mem_stall are combinational; they are 0 whenever the requests are 0.
//  IDLE:
//   - mem_req & (~if_req | starve_cnt<STARVE_LIMIT) -> SERVE_MEM.
//     Latch mem_addr, mem_wdata and mem_wr into ram_addr, ram_wdata and ram_we; set ram_en=1.
//   - else if_req -> SERVE_IF. Latch if_addr; ram_we=0; ram_en=1.
//   - else stay in IDLE.
//  starve_cnt:
//   - +1 when MEM is granted while if_req=1 (saturates at STARVE_LIMIT).
//   - cleared on an IF grant.
//  SERVE_x:
//   - ram_en and the latched ram_addr/ram_we/ram_wdata are held stable while in this state.
//   - On the edge where ram_ready=1: capture ram_rdata into x_rdata (also done for stores;
//     the value is don't-care), set x_done=1, ram_en=0, ram_we=0, go to RESP.
//  RESP: x_done is high for exactly this cycle; the next edge clears it and goes to IDLE.
//   Requests are not arbitrated in RESP, so the requester has this cycle to drop or renew req.
//  Latency: req in IDLE at cycle 0 -> ram_en at 1 -> ready at cycle k>=1 -> done at k+1 -> IDLE at k+2.
//   Minimum 2 cycles req-to-done.
//  x_rdata holds its value until the next completion for that requester.
//  Request withdrawn mid-SERVE: the access still completes and done still pulses; no abort.
//  Request address/data changes mid-SERVE have no effect (latched values are used).
//  Both requests arriving in the same cycle: MEM wins unless starve_cnt==STARVE_LIMIT.
//  Reset mid-access: the FSM aborts to IDLE and ram_en drops at that edge; no done pulse is issued.
// TESTING
//  1. IF only, ram_ready tied 1, if_addr=0x100, ram_rdata=0xE3A01005
//     -> ram_en in cycle 1; if_done + if_rdata=0xE3A01005 in cycle 2; freeze=1 in cycles 0-1, 0 in cycle 2.
//  2. Store: mem_wr=1, mem_addr=0x400, mem_wdata=0xDEADBEEF, ram_ready 0 for 3 cycles, then 1
//     -> ram_we=1, ram_addr=0x400 held for 4 cycles; single mem_done pulse; mem_stall=1 until then.
//  3. if_req and mem_req both high at cycle 0 -> MEM served first; IF granted in the IDLE cycle
//     after RESP; both done pulses seen, MEM before IF.
//  4. STARVE_LIMIT=3, if_req held, mem_req renewed every IDLE -> exactly 3 MEM grants,
//     then an IF grant; starve_cnt returns to 0.
//  5. rst=0 asserted during SERVE_MEM with ram_ready=0 -> next edge: ram_en=0, all outputs 0, state IDLE,
//     no mem_done; after release with mem_req still high, a fresh access starts.
//  6. mem_req dropped after grant -> access completes; mem_done pulses once; no second grant.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port instruction/data memory between the fetch (IF) and load/store (MEM) stages.
// MEM wins contention until STARVE_LIMIT consecutive contended MEM grants, then IF is forced through.
module mem_port_arbiter #(
  parameter int ADDRESS_LEN  = 32,
  parameter int DATA_LEN     = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [ADDRESS_LEN-1:0] if_addr,
  output logic [DATA_LEN-1:0]    if_rdata,
  output logic                   if_done,
  input  logic                   mem_req,
  input  logic                   mem_wr,
  input  logic [ADDRESS_LEN-1:0] mem_addr,
  input  logic [DATA_LEN-1:0]    mem_wdata,
  output logic [DATA_LEN-1:0]    mem_rdata,
  output logic                   mem_done,
  output logic                   ram_en,
  output logic                   ram_we,
  output logic [ADDRESS_LEN-1:0] ram_addr,
  output logic [DATA_LEN-1:0]    ram_wdata,
  input  logic [DATA_LEN-1:0]    ram_rdata,
  input  logic                   ram_ready,
  output logic                   freeze,
  output logic                   mem_stall,
  output logic [1:0]             dbg_state
);

  // Handshake: a requester raises x_req and holds it (with stable address/data) until x_done
  // pulses for one cycle; x_rdata is valid in that cycle and held until the next completion.
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_IF  = 2'd1,
    SERVE_MEM = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   ram_en_q;
  logic                   ram_we_q;
  logic [ADDRESS_LEN-1:0] ram_addr_q;
  logic [DATA_LEN-1:0]    ram_wdata_q;
  logic [DATA_LEN-1:0]    if_rdata_q;
  logic [DATA_LEN-1:0]    mem_rdata_q;
  logic                   if_done_q;
  logic                   mem_done_q;
  logic [CW-1:0]          starve_cnt_q;
  logic                   mem_wins;

  // MEM takes the port unless IF has already lost STARVE_LIMIT contended rounds in a row.
  assign mem_wins = mem_req && (!if_req || (starve_cnt_q < LIMIT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_done_q    <= 1'b0;
      mem_done_q   <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_wins) begin
            state_q     <= SERVE_MEM;
            ram_en_q    <= 1'b1;
            ram_we_q    <= mem_wr;
            ram_addr_q  <= mem_addr;
            ram_wdata_q <= mem_wdata;
            if (if_req && (starve_cnt_q != LIMIT)) starve_cnt_q <= starve_cnt_q + 1'b1;
          end else if (if_req) begin
            state_q      <= SERVE_IF;
            ram_en_q     <= 1'b1;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= if_addr;
            starve_cnt_q <= '0;
          end
        end
        SERVE_IF: begin
          if (ram_ready) begin
            state_q    <= RESP;
            if_rdata_q <= ram_rdata;
            if_done_q  <= 1'b1;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
          end
        end
        SERVE_MEM: begin
          if (ram_ready) begin
            state_q     <= RESP;
            mem_rdata_q <= ram_rdata;
            mem_done_q  <= 1'b1;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
          end
        end
        RESP: begin
          state_q    <= IDLE;
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;
  assign freeze    = if_req & ~if_done_q;
  assign mem_stall = mem_req & ~mem_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cycle-exact cases, then randomized contention scenarios
// checked against a transaction-order model and a behavioural memory.
module tb_mem_port_arbiter;

  localparam int LIMIT = 3;
  localparam int GW    = 66;
  localparam logic [31:0] IF_BASE  = 32'h0000_1000;
  localparam logic [31:0] MEM_BASE = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_wr;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, ram_addr, ram_wdata;
  logic        if_done, mem_done, ram_en, ram_we, freeze, mem_stall;
  logic [1:0]  dbg_state;
  wire  [31:0] ram_rdata;
  wire         ram_ready;

  logic        auto_ram = 1'b0;
  logic        auto_ready = 1'b0;
  logic [31:0] auto_rdata = 32'h0;
  logic        dir_ready;
  logic [31:0] dir_rdata;

  assign ram_ready = auto_ram ? auto_ready : dir_ready;
  assign ram_rdata = auto_ram ? auto_rdata : dir_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDRESS_LEN(32), .DATA_LEN(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .freeze(freeze), .mem_stall(mem_stall), .dbg_state(dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory contents before any store: a fixed scramble of the address.
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  logic [31:0] ram_model[logic [31:0]];
  logic [31:0] exp_mem[logic [31:0]];

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return ram_model.exists(a) ? ram_model[a] : init_val(a);
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : init_val(a);
  endfunction

  // Expected grant order: {is_if, we, addr, wdata}
  logic [GW-1:0] exp_q[$];
  logic [GW-1:0] cur;
  bit            cur_valid = 0;
  bit            prev_en = 0;
  int            wait_cnt = 0;

  // Memory responder and grant monitor used by the randomized phase.
  always begin
    tick();
    if (!auto_ram) begin
      prev_en   = 0;
      cur_valid = 0;
    end else if (ram_en) begin
      if (!prev_en) begin
        check_eq("grant_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          cur       = exp_q.pop_front();
          cur_valid = 1;
        end
        wait_cnt = $urandom_range(0, 3);
      end
      if (cur_valid) begin
        check_eq("grant_addr", ram_addr, cur[63:32]);
        check_eq("grant_we", 32'(ram_we), 32'(cur[64]));
        if (cur[64]) check_eq("grant_wdata", ram_wdata, cur[31:0]);
      end
      if (wait_cnt <= 0) begin
        auto_ready = 1'b1;
        if (ram_we) begin
          ram_model[ram_addr] = ram_wdata;
          auto_rdata = $urandom;
        end else begin
          auto_rdata = model_read(ram_addr);
        end
      end else begin
        auto_ready = 1'b0;
        auto_rdata = $urandom;
      end
      wait_cnt--;
      prev_en = 1;
    end else begin
      if (if_done || mem_done) begin
        check_eq("done_owner", 32'({if_done, mem_done}), (cur_valid && cur[65]) ? 32'd2 : 32'd1);
        cur_valid = 0;
      end
      auto_ready = 1'($urandom_range(0, 1));
      auto_rdata = $urandom;
      prev_en    = 0;
    end
  end

  logic [31:0] sc_ia;
  logic [31:0] sc_ma[6];
  logic        sc_mw[6];
  logic [31:0] sc_md[6];
  int          model_starve = 0;

  task automatic drive_if(input logic [31:0] a);
    int n;
    if_addr = a;
    if_req  = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (!if_done) check_eq("freeze_wait", 32'(freeze), 32'd1);
    end while (!if_done && n < 100);
    check_eq("if_done", 32'(if_done), 32'd1);
    check_eq("if_rdata", if_rdata, init_val(a));
    check_eq("freeze_done", 32'(freeze), 32'd0);
    if_req = 1'b0;
  endtask

  task automatic drive_mem(input int k);
    int n;
    mem_req = 1'b1;
    for (int i = 0; i < k; i++) begin
      mem_addr  = sc_ma[i];
      mem_wr    = sc_mw[i];
      mem_wdata = sc_md[i];
      n = 0;
      do begin
        tick();
        n++;
        if (!mem_done) check_eq("stall_wait", 32'(mem_stall), 32'd1);
      end while (!mem_done && n < 100);
      check_eq("mem_done", 32'(mem_done), 32'd1);
      if (sc_mw[i]) exp_mem[sc_ma[i]] = sc_md[i];
      else          check_eq("mem_load", mem_rdata, exp_read(sc_ma[i]));
    end
    mem_req = 1'b0;
    mem_wr  = 1'b0;
  endtask

  // IF (optional) and k back-to-back MEM requests start in the same IDLE cycle; MEM renews in RESP.
  task automatic run_scenario(input bit ifp, input int k);
    int st;
    bit pend;
    sc_ia = IF_BASE + 32'(4 * $urandom_range(0, 255));
    for (int i = 0; i < k; i++) begin
      sc_ma[i] = MEM_BASE + 32'(4 * $urandom_range(0, 7));
      sc_mw[i] = 1'($urandom_range(0, 1));
      sc_md[i] = $urandom;
    end
    st   = model_starve;
    pend = ifp;
    for (int i = 0; i < k; i++) begin
      if (pend && st == LIMIT) begin
        exp_q.push_back({1'b1, 1'b0, sc_ia, 32'h0});
        pend = 0;
        st   = 0;
      end
      exp_q.push_back({1'b0, sc_mw[i], sc_ma[i], sc_md[i]});
      if (pend && st < LIMIT) st++;
    end
    if (pend) begin
      exp_q.push_back({1'b1, 1'b0, sc_ia, 32'h0});
      st = 0;
    end
    model_starve = st;
    fork
      begin if (ifp) drive_if(sc_ia); end
      begin if (k > 0) drive_mem(k); end
    join
    repeat ($urandom_range(1, 3)) tick();
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_wr = 1'b0;
    if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
    dir_ready = 1'b0; dir_rdata = 32'h0;
    repeat (3) tick();
    check_eq("rst_ram_en", 32'(ram_en), 32'd0);
    check_eq("rst_ram_we", 32'(ram_we), 32'd0);
    check_eq("rst_ram_addr", ram_addr, 32'h0);
    check_eq("rst_ram_wdata", ram_wdata, 32'h0);
    check_eq("rst_if_rdata", if_rdata, 32'h0);
    check_eq("rst_mem_rdata", mem_rdata, 32'h0);
    check_eq("rst_dones", 32'({if_done, mem_done}), 32'd0);
    check_eq("rst_freeze_stall", 32'({freeze, mem_stall}), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b1;
    tick();

    // IF only, ram_ready tied high: minimum latency
    dir_ready = 1'b1; dir_rdata = 32'hE3A0_1005;
    if_addr = 32'h100; if_req = 1'b1;
    #1;
    check_eq("t1_freeze_c0", 32'(freeze), 32'd1);
    check_eq("t1_en_c0", 32'(ram_en), 32'd0);
    tick();
    check_eq("t1_en_c1", 32'(ram_en), 32'd1);
    check_eq("t1_addr_c1", ram_addr, 32'h100);
    check_eq("t1_we_c1", 32'(ram_we), 32'd0);
    check_eq("t1_done_c1", 32'(if_done), 32'd0);
    check_eq("t1_freeze_c1", 32'(freeze), 32'd1);
    tick();
    check_eq("t1_done_c2", 32'(if_done), 32'd1);
    check_eq("t1_rdata_c2", if_rdata, 32'hE3A0_1005);
    check_eq("t1_en_c2", 32'(ram_en), 32'd0);
    check_eq("t1_freeze_c2", 32'(freeze), 32'd0);
    if_req = 1'b0; dir_ready = 1'b0;
    tick();
    check_eq("t1_done_c3", 32'(if_done), 32'd0);
    check_eq("t1_en_c3", 32'(ram_en), 32'd0);
    check_eq("t1_rdata_hold", if_rdata, 32'hE3A0_1005);

    // Store with three wait cycles
    mem_wr = 1'b1; mem_addr = 32'h400; mem_wdata = 32'hDEAD_BEEF; mem_req = 1'b1;
    #1;
    check_eq("t2_stall_c0", 32'(mem_stall), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_eq("t2_en", 32'(ram_en), 32'd1);
      check_eq("t2_we", 32'(ram_we), 32'd1);
      check_eq("t2_addr", ram_addr, 32'h400);
      check_eq("t2_wdata", ram_wdata, 32'hDEAD_BEEF);
      check_eq("t2_done_early", 32'(mem_done), 32'd0);
      check_eq("t2_stall", 32'(mem_stall), 32'd1);
      if (c == 4) dir_ready = 1'b1;
    end
    tick();
    check_eq("t2_done", 32'(mem_done), 32'd1);
    check_eq("t2_en_off", 32'(ram_en), 32'd0);
    check_eq("t2_we_off", 32'(ram_we), 32'd0);
    check_eq("t2_stall_off", 32'(mem_stall), 32'd0);
    mem_req = 1'b0; mem_wr = 1'b0; dir_ready = 1'b0;
    tick();
    check_eq("t2_done_once", 32'(mem_done), 32'd0);

    // Reset during a stalled load, then a fresh access after release
    mem_addr = 32'h500; mem_req = 1'b1;
    tick();
    check_eq("t5_en_c1", 32'(ram_en), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    check_eq("t5_en_rst", 32'(ram_en), 32'd0);
    check_eq("t5_we_rst", 32'(ram_we), 32'd0);
    check_eq("t5_addr_rst", ram_addr, 32'h0);
    check_eq("t5_wdata_rst", ram_wdata, 32'h0);
    check_eq("t5_if_rdata_rst", if_rdata, 32'h0);
    check_eq("t5_mem_rdata_rst", mem_rdata, 32'h0);
    check_eq("t5_dones_rst", 32'({if_done, mem_done}), 32'd0);
    rst = 1'b1;
    tick();
    check_eq("t5_en_again", 32'(ram_en), 32'd1);
    check_eq("t5_addr_again", ram_addr, 32'h500);
    check_eq("t5_no_done", 32'(mem_done), 32'd0);
    dir_rdata = 32'h0BAD_F00D; dir_ready = 1'b1;
    tick();
    check_eq("t5_done", 32'(mem_done), 32'd1);
    check_eq("t5_rdata", mem_rdata, 32'h0BAD_F00D);
    mem_req = 1'b0; dir_ready = 1'b0;
    tick();

    // Request withdrawn and address changed after grant
    mem_addr = 32'h600; mem_req = 1'b1;
    tick();
    check_eq("t6_en_c1", 32'(ram_en), 32'd1);
    mem_req = 1'b0; mem_addr = 32'h700;
    tick();
    check_eq("t6_en_c2", 32'(ram_en), 32'd1);
    check_eq("t6_addr_c2", ram_addr, 32'h600);
    dir_rdata = 32'h600D_CAFE; dir_ready = 1'b1;
    tick();
    check_eq("t6_done", 32'(mem_done), 32'd1);
    check_eq("t6_rdata", mem_rdata, 32'h600D_CAFE);
    check_eq("t6_stall", 32'(mem_stall), 32'd0);
    dir_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("t6_no_regrant", 32'(ram_en), 32'd0);
      check_eq("t6_no_redone", 32'(mem_done), 32'd0);
    end
    check_eq("t6_rdata_hold", mem_rdata, 32'h600D_CAFE);

    // Randomized contention against the transaction-order model
    auto_ram = 1'b1;
    tick();
    run_scenario(1'b1, 4);
    run_scenario(1'b1, 4);
    run_scenario(1'b1, 1);
    for (int s = 0; s < 40; s++) begin
      bit ifp;
      int k;
      ifp = 1'($urandom_range(0, 1));
      k   = $urandom_range(0, 5);
      if (!ifp && k == 0) k = 1;
      run_scenario(ifp, k);
    end
    repeat (3) tick();
    check_eq("grants_outstanding", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
